tick_step_controller: RTL and testbench

- Sequences the FFT datapath stage-by-stage, one stage-enable strobe per divided tick (free-run mode) or per user step request (single-step mode), for on-board bring-up and slow observation.
- Replaces the divided-clock approach: everything runs on the single system clock; the datapath sees one-cycle enables only.
- Sits between the board-level control inputs (buttons/switches) and the FFT stage datapath.

---
 rtl/tick_step_controller_if.sv | 37 +++
 rtl/tick_step_controller.sv | 118 +++++++++++
 tb/tb_tick_step_controller.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/tick_step_controller_if.sv
// Control/status bundle between board-level controls and the tick/step stage sequencer.
// The stall input exists only when TSC_STALL_EN is defined.
interface tick_step_controller_if #(
    parameter int CNT_BITS   = 19,
    parameter int STAGE_BITS = 4
);
    logic                  start;
    logic                  abort;
    logic                  mode_step;
    logic                  step_req;
    logic                  period_wr;
    logic [CNT_BITS-1:0]   period_in;
`ifdef TSC_STALL_EN
    logic                  stall;
`endif
    logic                  stage_en;
    logic [STAGE_BITS-1:0] stage_idx;
    logic                  tick;
    logic                  busy;
    logic                  done;

    modport master (
`ifdef TSC_STALL_EN
        output stall,
`endif
        output start, abort, mode_step, step_req, period_wr, period_in,
        input  stage_en, stage_idx, tick, busy, done
    );

    modport slave (
`ifdef TSC_STALL_EN
        input  stall,
`endif
        input  start, abort, mode_step, step_req, period_wr, period_in,
        output stage_en, stage_idx, tick, busy, done
    );
endinterface

// File: rtl/tick_step_controller.sv
// Stage sequencer for the FFT datapath: one-cycle stage enables per divided tick or per step request.
// Optional stall input is enabled by defining TSC_STALL_EN.
module tick_step_controller #(
    parameter int CNT_BITS   = 19,
    parameter int STAGE_BITS = 4,
    parameter int NUM_STAGES = 10
) (
    input logic                   clk,
    input logic                   rst,
    tick_step_controller_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2,
        FIN  = 2'd3
    } state_t;

    localparam logic [STAGE_BITS-1:0] LAST_STAGE = STAGE_BITS'(NUM_STAGES - 1);

    state_t                state_reg, state_next;
    logic [CNT_BITS-1:0]   cnt_reg, cnt_next;
    logic [CNT_BITS-1:0]   period_reg, period_next;
    logic [STAGE_BITS-1:0] idx_reg, idx_next;
    logic                  en_reg, en_next;
    logic                  stall_w, match_w, last_w;
    logic                  tick_w, busy_w, done_w;

`ifdef TSC_STALL_EN
    assign stall_w = bus.stall;
`else
    assign stall_w = 1'b0;
`endif

    // A stalled counter neither advances nor matches, so no tick can fire.
    assign match_w = (cnt_reg == period_reg) && !stall_w;
    assign last_w  = en_reg && (idx_reg == LAST_STAGE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next = bus.mode_step ? STEP : RUN;
                end
            end
            RUN, STEP: begin
                if (bus.abort) begin
                    state_next = IDLE;
                end else if (last_w) begin
                    state_next = FIN;
                end
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        tick_w = (state_reg == RUN) && match_w;
        busy_w = (state_reg == RUN) || (state_reg == STEP);
        done_w = (state_reg == FIN);
    end

    // Datapath next values; abort and the final strobe both leave the counter at 0
    // and cancel any strobe that would otherwise be scheduled.
    always_comb begin
        cnt_next    = '0;
        en_next     = 1'b0;
        period_next = period_reg;
        idx_next    = idx_reg;
        if (!busy_w && bus.period_wr) begin
            period_next = bus.period_in;
        end
        if (state_reg == RUN && !bus.abort && !last_w) begin
            en_next = match_w;
            if (!match_w) begin
                cnt_next = stall_w ? cnt_reg : cnt_reg + 1'b1;
            end
        end
        if (state_reg == STEP && !bus.abort && !last_w) begin
            en_next = bus.step_req && !en_reg && !stall_w;
        end
        if (state_next != RUN && state_next != STEP) begin
            idx_next = '0;
        end else if (en_reg) begin
            idx_next = idx_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg    <= '0;
            period_reg <= '1;
            idx_reg    <= '0;
            en_reg     <= 1'b0;
        end else begin
            cnt_reg    <= cnt_next;
            period_reg <= period_next;
            idx_reg    <= idx_next;
            en_reg     <= en_next;
        end
    end

    assign bus.stage_en  = en_reg;
    assign bus.stage_idx = idx_reg;
    assign bus.tick      = tick_w;
    assign bus.busy      = busy_w;
    assign bus.done      = done_w;
endmodule

// File: tb/tb_tick_step_controller.sv
// Randomized self-checking bench for tick_step_controller (CNT_BITS=8, NUM_STAGES=4).
// Expected strobes are derived from period arithmetic and request lists; stall scenario needs TSC_STALL_EN.
module tb_tick_step_controller;
    localparam int CB   = 8;
    localparam int SB   = 4;
    localparam int NS   = 4;
    localparam int MAXC = 1200;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tick_step_controller_if #(.CNT_BITS(CB), .STAGE_BITS(SB)) bus();

    tick_step_controller #(.CNT_BITS(CB), .STAGE_BITS(SB), .NUM_STAGES(NS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    bit exp_en   [MAXC];
    bit exp_tick [MAXC];
    bit req_arr  [MAXC];
    bit stall_arr[MAXC];

    task automatic idle_inputs();
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.mode_step = 1'b0;
        bus.step_req  = 1'b0;
        bus.period_wr = 1'b0;
        bus.period_in = '0;
`ifdef TSC_STALL_EN
        bus.stall     = 1'b0;
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({bus.stage_en, bus.tick, bus.busy, bus.done, bus.stage_idx} !== 8'h00) begin
            bad++;
            $display("FAIL reset_hold outputs got=%h exp=00", {bus.stage_en, bus.tick, bus.busy, bus.done, bus.stage_idx});
        end
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.period_wr = 1'b1; bus.period_in = 8'd3;
        @(posedge clk); #1;
        idle_inputs();
        repeat (6) @(posedge clk);
        #1;
        total++;
        if (bus.busy !== 1'b1 || bus.stage_idx !== 4'd1) begin
            bad++;
            $display("FAIL reset_prerun busy/idx got=%b/%0d exp=1/1", bus.busy, bus.stage_idx);
        end
        #1 rst = 1'b1;
        #1;
        total++;
        if ({bus.stage_en, bus.tick, bus.busy, bus.done, bus.stage_idx} !== 8'h00) begin
            bad++;
            $display("FAIL reset_midrun outputs got=%h exp=00", {bus.stage_en, bus.tick, bus.busy, bus.done, bus.stage_idx});
        end
        $display("reset mid-run: outputs=%h", {bus.stage_en, bus.tick, bus.busy, bus.done, bus.stage_idx});
        @(negedge clk) rst = 1'b0;
    endtask

    // Free-run: k-th strobe one cycle after the cycle holding the (k*(P+1))-th unstalled count.
    task automatic test_free_run(input string name, input int p, input bit wr, input int abort_at,
                                 input int wr_busy_at, input int st_lo, input int st_hi);
        int  act, k, last_en, done_c, end_c, nen, e_idx;
        bit  t, ab, e_en, e_tick, e_busy, e_done;
        for (int c = 0; c < MAXC; c++) begin
            exp_en[c]    = 1'b0;
            exp_tick[c]  = 1'b0;
            stall_arr[c] = (c >= st_lo) && (c <= st_hi);
        end
        act = 0; k = 0; last_en = -1;
        for (int c = 0; c < MAXC - 1; c++) begin
            if (last_en >= 0 && c > last_en) break;
            t = !stall_arr[c] && ((act % (p + 1)) == p);
            exp_tick[c] = t;
            if (t && k < NS) begin
                exp_en[c + 1] = 1'b1;
                k++;
                if (k == NS) last_en = c + 1;
            end
            if (!stall_arr[c]) act++;
        end
        done_c = last_en + 1;
        end_c  = (abort_at >= 0) ? abort_at + 4 : done_c + 3;

        @(posedge clk); #1;
        bus.start = 1'b1; bus.mode_step = 1'b0; bus.period_wr = wr; bus.period_in = CB'(p);
        @(posedge clk); #1;
        nen = 0;
        for (int c = 0; c <= end_c; c++) begin
            bus.start     = (c == 2) && (abort_at < 0 || c <= abort_at);
            bus.mode_step = (c == 2);
            bus.step_req  = 1'($urandom % 2);
            bus.abort     = (c == abort_at);
            bus.period_wr = (c == wr_busy_at);
            bus.period_in = 8'd7;
`ifdef TSC_STALL_EN
            bus.stall     = stall_arr[c];
`endif
            @(negedge clk);
            ab     = (abort_at >= 0) && (c > abort_at);
            e_en   = !ab && exp_en[c];
            e_tick = !ab && exp_tick[c];
            e_busy = !ab && (c <= last_en);
            e_done = !ab && (c == done_c);
            e_idx  = ab ? 0 : nen;
            total++;
            if (bus.stage_en !== e_en) begin
                bad++;
                $display("FAIL %s c=%0d stage_en got=%b exp=%b", name, c, bus.stage_en, e_en);
            end
            total++;
            if (bus.tick !== e_tick) begin
                bad++;
                $display("FAIL %s c=%0d tick got=%b exp=%b", name, c, bus.tick, e_tick);
            end
            total++;
            if (bus.busy !== e_busy || bus.done !== e_done) begin
                bad++;
                $display("FAIL %s c=%0d busy/done got=%b/%b exp=%b/%b", name, c, bus.busy, bus.done, e_busy, e_done);
            end
            if (e_busy || ab) begin
                total++;
                if (bus.stage_idx !== SB'(e_idx)) begin
                    bad++;
                    $display("FAIL %s c=%0d stage_idx got=%0d exp=%0d", name, c, bus.stage_idx, e_idx);
                end
            end
            if (e_en) nen++;
            @(posedge clk); #1;
        end
        idle_inputs();
        $display("%s: P=%0d abort_at=%0d strobes=%0d done_cycle=%0d", name, p, abort_at, nen, done_c);
    endtask

    // Single-step: a request yields a strobe next cycle unless a strobe is already high.
    task automatic test_step(input string name, input bit rnd, input int abort_in);
        int k, last_en, done_c, end_c, busy_end, nen, e_idx, abort_at;
        bit ab, e_en, e_busy, e_done;
        abort_at = abort_in;
        for (int c = 0; c < MAXC; c++) begin
            exp_en[c]  = 1'b0;
            req_arr[c] = rnd ? 1'($urandom % 2) : (c == 5 || c == 6 || c == 20);
        end
        k = 0; last_en = -1;
        for (int c = 0; c < 300; c++) begin
            if (k < NS && req_arr[c] && !exp_en[c] && (abort_at < 0 || c < abort_at)) begin
                exp_en[c + 1] = 1'b1;
                k++;
                if (k == NS) last_en = c + 1;
            end
        end
        if (last_en < 0 && abort_at < 0) abort_at = 290;
        busy_end = (last_en >= 0) ? last_en : MAXC;
        done_c   = (last_en >= 0) ? last_en + 1 : MAXC;
        end_c    = (abort_at >= 0) ? abort_at + 4 : done_c + 3;

        @(posedge clk); #1;
        bus.start = 1'b1; bus.mode_step = 1'b1;
        @(posedge clk); #1;
        nen = 0;
        for (int c = 0; c <= end_c; c++) begin
            bus.start     = (c == 3) && (abort_at < 0 || c <= abort_at) && (c <= busy_end);
            bus.mode_step = 1'($urandom % 2);
            bus.step_req  = req_arr[c];
            bus.abort     = (c == abort_at);
            @(negedge clk);
            ab     = (abort_at >= 0) && (c > abort_at);
            e_en   = !ab && exp_en[c];
            e_busy = !ab && (c <= busy_end);
            e_done = !ab && (c == done_c);
            e_idx  = ab ? 0 : nen;
            total++;
            if (bus.stage_en !== e_en || bus.tick !== 1'b0) begin
                bad++;
                $display("FAIL %s c=%0d stage_en/tick got=%b/%b exp=%b/0", name, c, bus.stage_en, bus.tick, e_en);
            end
            total++;
            if (bus.busy !== e_busy || bus.done !== e_done) begin
                bad++;
                $display("FAIL %s c=%0d busy/done got=%b/%b exp=%b/%b", name, c, bus.busy, bus.done, e_busy, e_done);
            end
            if (e_busy || ab) begin
                total++;
                if (bus.stage_idx !== SB'(e_idx)) begin
                    bad++;
                    $display("FAIL %s c=%0d stage_idx got=%0d exp=%0d", name, c, bus.stage_idx, e_idx);
                end
            end
            if (e_en) nen++;
            @(posedge clk); #1;
        end
        idle_inputs();
        $display("%s: abort_at=%0d strobes=%0d done_cycle=%0d", name, abort_at, nen, done_c);
    endtask

    initial begin
        int p, a;
        idle_inputs();
        test_reset();
        test_free_run("rst_period_255", 255, 1'b0, 258, -1, -1, -1);
        test_free_run("free_p3", 3, 1'b1, -1, -1, -1, -1);
        test_free_run("period_wr_busy", 3, 1'b0, -1, 5, -1, -1);
        test_free_run("period_kept", 3, 1'b0, -1, -1, -1, -1);
        test_free_run("min_period", 0, 1'b1, -1, -1, -1, -1);
        test_free_run("abort_tick2", 3, 1'b1, 7, -1, -1, -1);
        for (int i = 0; i < 6; i++) begin
            p = int'($urandom_range(0, 9));
            a = ($urandom % 2 == 0) ? -1 : int'($urandom_range(0, NS * (p + 1)));
            test_free_run("back_to_back", p, 1'b1, a, -1, -1, -1);
        end
        test_step("step_fixed", 1'b0, 30);
        for (int i = 0; i < 3; i++) begin
            test_step("step_rand", 1'b1, -1);
        end
`ifdef TSC_STALL_EN
        test_free_run("stall_10", 3, 1'b1, -1, -1, 5, 14);
        test_free_run("stall_abort", 2, 1'b1, 9, -1, 4, 12);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
